// File: rtl/mux4_sched_pkg.sv
// mux4_sched_pkg: shared sizes, FSM states and one-hot helper for the round-robin mux scheduler
package mux4_sched_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W = 2;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction
endpackage

// File: rtl/mux_4x1.sv
// mux_4x1: combinational 4:1 bit mux selected by {s1,s0}
module mux_4x1 (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic s1,
  input  logic s0,
  output logic y
);
  always_comb
    case ({s1, s0})
      2'd0:    y = i0;
      2'd1:    y = i1;
      2'd2:    y = i2;
      default: y = i3;
    endcase
endmodule

// File: rtl/rr_pick.sv
// rr_pick: first requester found scanning upward from ptr, wrapping mod 4
module rr_pick
  import mux4_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);
  always_comb begin
    any = |req;
    idx = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[ptr + SEL_W'(k)]) idx = ptr + SEL_W'(k);
  end
endmodule

// File: rtl/mux4_rr_sched.sv
// mux4_rr_sched: round-robin burst scheduler driving a shared 4:1 mux into a valid/ready output register
module mux4_rr_sched
  import mux4_sched_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] data_in,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] grant,
  output logic               s1,
  output logic               s0,
  output logic               y,
  output logic               out_valid,
  output logic               busy
);
  localparam logic [CNT_W-1:0] MAX_B = CNT_W'(MAX_BURST);
  state_t state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [SEL_W-1:0] sel, sel_nxt, ptr, ptr_nxt, idx;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic y_nxt, ov_nxt, any, mux_y, ld, rel;
  assign ld = !out_valid || out_ready;
  assign {s1, s0} = sel;
  assign busy = state == GRANT;
  rr_pick u_pick (
    .req(req),
    .ptr(ptr),
    .any(any),
    .idx(idx)
  );
  mux_4x1 u_mux (
    .i0(data_in[0]),
    .i1(data_in[1]),
    .i2(data_in[2]),
    .i3(data_in[3]),
    .s1(s1),
    .s0(s0),
    .y (mux_y)
  );
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    sel_nxt = sel;
    ptr_nxt = ptr;
    cnt_nxt = cnt;
    y_nxt = y;
    ov_nxt = out_valid;
    rel = 1'b0;
    if (state == IDLE) begin
      if (ld) ov_nxt = 1'b0;
      if (any) begin
        grant_nxt = onehot(idx);
        sel_nxt = idx;
        cnt_nxt = '0;
        state_nxt = GRANT;
      end
    end else if (!req[sel]) begin
      if (ld) ov_nxt = 1'b0;
      rel = 1'b1;
    end else if (ld) begin
      y_nxt = mux_y;
      ov_nxt = 1'b1;
      cnt_nxt = cnt + 1'b1;
      rel = cnt_nxt == MAX_B;
    end
    // selects stay on the last requester after release; only grant clears
    if (rel) begin
      grant_nxt = '0;
      ptr_nxt = sel + 1'b1;
      state_nxt = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      sel <= '0;
      ptr <= '0;
      cnt <= '0;
      y <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      sel <= sel_nxt;
      ptr <= ptr_nxt;
      cnt <= cnt_nxt;
      y <= y_nxt;
      out_valid <= ov_nxt;
    end
endmodule

// File: tb/tb_mux4_rr_sched.sv
// tb_mux4_rr_sched: directed tests of the round-robin burst scheduler
module tb_mux4_rr_sched;
  logic clk = 1'b0, reset = 1'b0, out_ready = 1'b0;
  logic [3:0] req = '0, data_in = '0, grant;
  logic s1, s0, y, out_valid, busy;
  logic [8:0] st;
  int pass_cnt = 0, total = 0;
  assign st = {grant, s1, s0, y, out_valid, busy};
  always #5 clk = ~clk;
  mux4_rr_sched dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .data_in(data_in),
    .out_ready(out_ready),
    .grant(grant),
    .s1(s1),
    .s0(s0),
    .y(y),
    .out_valid(out_valid),
    .busy(busy)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b0;
    req = '0;
    data_in = '0;
    out_ready = 1'b1;
    #3;
    reset = 1'b1;
  endtask
  task automatic test_reset;
    #2;
    total++;
    if (st !== 9'b0000_00_000) $display("FAIL reset_init: got %b want %b", st, 9'b0000_00_000);
    else pass_cnt++;
    do_reset;
    req = 4'b0001;
    data_in = 4'b0001;
    tick;
    tick;
    total++;
    if (st !== 9'b0001_00_111) $display("FAIL reset_pre: got %b want %b", st, 9'b0001_00_111);
    else pass_cnt++;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (st !== 9'b0000_00_000) $display("FAIL reset_async: got %b want %b", st, 9'b0000_00_000);
    else pass_cnt++;
    #2;
    reset = 1'b1;
    req = '0;
  endtask
  task automatic test_single;
    logic [3:0] seq = 4'b1101;
    logic [8:0] exp;
    do_reset;
    req = 4'b0100;
    data_in = 4'b0100;
    tick;
    total++;
    if (st !== 9'b0100_10_001) $display("FAIL single_grant: got %b want %b", st, 9'b0100_10_001);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      data_in[2] = seq[i];
      tick;
      exp = {(i < 3) ? 4'b0100 : 4'b0000, 2'b10, seq[i], 1'b1, i < 3};
      total++;
      if (st !== exp) $display("FAIL single_beat%0d: got %b want %b", i, st, exp);
      else pass_cnt++;
    end
    req = 4'b1111;
    tick;
    total++;
    if (st !== 9'b1000_11_101) $display("FAIL single_next_ptr: got %b want %b", st, 9'b1000_11_101);
    else pass_cnt++;
  endtask
  task automatic test_rr_all;
    logic [3:0] oh;
    logic [1:0] sl;
    logic ylast;
    logic [8:0] exp;
    do_reset;
    req = 4'b1111;
    data_in = 4'b0110;
    ylast = 1'b0;
    for (int g = 0; g < 5; g++) begin
      sl = 2'(g % 4);
      oh = 4'b0001 << sl;
      tick;
      exp = {oh, sl, ylast, 1'b0, 1'b1};
      total++;
      if (st !== exp) $display("FAIL rr_grant%0d: got %b want %b", g, st, exp);
      else pass_cnt++;
      for (int b = 0; b < 4; b++) begin
        tick;
        ylast = data_in[sl];
        exp = {(b < 3) ? oh : 4'b0000, sl, ylast, 1'b1, b < 3};
        total++;
        if (st !== exp) $display("FAIL rr_g%0d_beat%0d: got %b want %b", g, b, st, exp);
        else pass_cnt++;
      end
    end
  endtask
  task automatic test_stall;
    do_reset;
    req = 4'b0001;
    data_in = 4'b0001;
    tick;
    tick;
    tick;
    total++;
    if (st !== 9'b0001_00_111) $display("FAIL stall_beat2: got %b want %b", st, 9'b0001_00_111);
    else pass_cnt++;
    out_ready = 1'b0;
    data_in = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if (st !== 9'b0001_00_111) $display("FAIL stall_hold%0d: got %b want %b", i, st, 9'b0001_00_111);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    tick;
    total++;
    if (st !== 9'b0001_00_011) $display("FAIL stall_beat3: got %b want %b", st, 9'b0001_00_011);
    else pass_cnt++;
    tick;
    total++;
    if (st !== 9'b0000_00_010) $display("FAIL stall_release: got %b want %b", st, 9'b0000_00_010);
    else pass_cnt++;
    req = '0;
    tick;
    total++;
    if (st !== 9'b0000_00_000) $display("FAIL stall_drain: got %b want %b", st, 9'b0000_00_000);
    else pass_cnt++;
  endtask
  task automatic test_drop;
    do_reset;
    req = 4'b0010;
    data_in = 4'b0010;
    tick;
    tick;
    tick;
    total++;
    if (st !== 9'b0010_01_111) $display("FAIL drop_beat2: got %b want %b", st, 9'b0010_01_111);
    else pass_cnt++;
    req = 4'b0101;
    tick;
    total++;
    if (st !== 9'b0000_01_100) $display("FAIL drop_release: got %b want %b", st, 9'b0000_01_100);
    else pass_cnt++;
    tick;
    total++;
    if (st !== 9'b0100_10_101) $display("FAIL drop_next: got %b want %b", st, 9'b0100_10_101);
    else pass_cnt++;
  endtask
  task automatic test_wrap;
    do_reset;
    req = 4'b0100;
    tick;
    req = '0;
    tick;
    total++;
    if (st !== 9'b0000_10_000) $display("FAIL wrap_rel2: got %b want %b", st, 9'b0000_10_000);
    else pass_cnt++;
    req = 4'b1001;
    tick;
    total++;
    if (st !== 9'b1000_11_001) $display("FAIL wrap_grant3: got %b want %b", st, 9'b1000_11_001);
    else pass_cnt++;
    req = 4'b0001;
    tick;
    total++;
    if (st !== 9'b0000_11_000) $display("FAIL wrap_rel3: got %b want %b", st, 9'b0000_11_000);
    else pass_cnt++;
    tick;
    total++;
    if (st !== 9'b0001_00_001) $display("FAIL wrap_grant0: got %b want %b", st, 9'b0001_00_001);
    else pass_cnt++;
  endtask
  initial begin
    test_reset;
    test_single;
    test_rr_all;
    test_stall;
    test_drop;
    test_wrap;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mux4_rr_sched.md
Name: mux4_rr_sched

Overview:
Round-robin scheduler that shares one 4:1 bit-mux datapath among four requesters. It drives the mux selects s1/s0 and holds each grant for a bounded burst. Selected data is registered into a valid/ready output stage.

Parameters:
MAX_BURST, 4, maximum beats per grant before forced release (legal 1..15).
CNT_W, 4, beat counter width; must satisfy 2**CNT_W > MAX_BURST.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  4  per-requester request, level; bit n = requester n
data_in  input  4  per-requester data bit; bit n feeds mux input n
out_ready  input  1  downstream accepts y this cycle
grant  output  4  one-hot registered grant; 0 when idle
s1  output  1  mux select MSB (registered)
s0  output  1  mux select LSB (registered)
y  output  1  registered selected data
out_valid  output  1  y holds an unaccepted beat
busy  output  1  high when state is GRANT

Behaviour:
- Reset (reset=0, async): state=IDLE, grant=0, s1=s0=0, y=0, out_valid=0, beat_cnt=0, ptr=0. busy=0.
- ptr (2 bits) = highest-priority requester index. Search order is ptr, ptr+1, ... mod 4.
- Output register load enable: ld = !out_valid || out_ready.
- IDLE state:
  - If ld: out_valid<=0.
  - If req!=0: pick winner w by round-robin from ptr; grant<=onehot(w); {s1,s0}<=w; beat_cnt<=0; go to GRANT.
  - Request-to-grant latency is 1 cycle.
- GRANT state, sel={s1,s0}:
  - req[sel]=1 and ld: y<=data_in[sel]; out_valid<=1; beat_cnt<=beat_cnt+1. This is one beat. y appears 1 cycle after the beat.
  - On the beat where beat_cnt+1==MAX_BURST: release.
  - req[sel]=0: release immediately, no beat. If ld, out_valid<=0.
  - Stall (req[sel]=1, !ld): y, out_valid, beat_cnt, grant and selects all hold.
  - Release: grant<=0, ptr<=sel+1 mod 4, state<=IDLE, selects keep their last value. Consequence: one dead cycle between consecutive grants.
- Drop of req during a stall: release still occurs; the pending y/out_valid is held until accepted.
- MAX_BURST=1: one beat per grant.
- All four requesting with ptr=0: order is 0,1,2,3,0,...
- ptr wraps 3→0.
- The data mux is combinational; only the selects and output stage are registered.

Decomposition:
- Package mux4_sched_pkg: NUM_REQ=4, SEL_W=2, state enum {IDLE, GRANT}.
- Sub-module rr_pick (combinational):
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: any, idx[1:0].
- Data selection instantiates the team's mux_4x1 (case-based, combinational) with s1/s0 and data_in bits as i0..i3.

Test Plan:
1. Assert reset=0 mid-burst with out_valid=1 → grant=0, s1=s0=0, y=0, out_valid=0, busy=0 without waiting for a clock edge.
2. req=0100 held, out_ready=1, data_in[2]=1,0,1,1 on cycles 1-4 → grant=0100 from cycle 1; y=1,0,1,1 with out_valid=1 on cycles 2-5; grant=0 at cycle 5; next winner search starts at 3.
3. req=1111 constant, MAX_BURST=4, out_ready=1 → grants 0001,0010,0100,1000,0001; each grant lasts 4 beats; one idle cycle between grants.
4. Grant on requester 0, out_ready=0 for 3 cycles after beat 2 → y, out_valid, grant frozen; exactly 4 beats are delivered in total; release follows the 4th beat.
5. req[1] drops after 2 beats while req[0] and req[2] are held → grant 0010 releases; only 2 beats delivered; next grant is 0100, not 0001.
6. ptr=3 with req=1001 → grant 1000 first, then 0001 after release.
